// File: rtl/sync_pkg.sv
// Shared definitions for the synchronous mux stage and its window averager.
package sync_pkg;

    // Sample width used by the mux stage and everything downstream of it.
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } avg_state_t;

endpackage

// File: rtl/sync_window_avg_if.sv
// Sample/handshake bundle between the controller and sync_window_avg.
// With SYNC_WINDOW_AVG_MINMAX_EN defined the bundle also carries win_min/win_max.
interface sync_window_avg_if
    import sync_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] x;
    logic             x_valid;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] avg;
    logic             avg_valid;
    logic             busy;
`ifdef SYNC_WINDOW_AVG_MINMAX_EN
    logic [WIDTH-1:0] win_min;
    logic [WIDTH-1:0] win_max;
`endif

    modport master (
        output x, x_valid, start, abort,
`ifdef SYNC_WINDOW_AVG_MINMAX_EN
        input  win_min, win_max,
`endif
        input  avg, avg_valid, busy
    );

    modport slave (
        input  x, x_valid, start, abort,
`ifdef SYNC_WINDOW_AVG_MINMAX_EN
        output win_min, win_max,
`endif
        output avg, avg_valid, busy
    );

endinterface

// File: rtl/sync_window_minmax.sv
// Running min/max over the accepted samples of one window; results are
// published on the same cycle the window mean is registered.
module sync_window_minmax
    import sync_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic             accept,
    input  logic             first,
    input  logic             commit,
    output logic [WIDTH-1:0] win_min,
    output logic [WIDTH-1:0] win_max
);
    logic [WIDTH-1:0] run_min_p0, run_max_p0;
    logic [WIDTH-1:0] cand_min, cand_max;

    // The first accepted sample seeds both trackers, so stale values from an
    // aborted window never leak into the next one.
    always_comb begin
        cand_min = (first || (x < run_min_p0)) ? x : run_min_p0;
        cand_max = (first || (x > run_max_p0)) ? x : run_max_p0;
    end

    // Stage p0: running trackers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_min_p0 <= '0;
            run_max_p0 <= '0;
        end else if (accept) begin
            run_min_p0 <= cand_min;
            run_max_p0 <= cand_max;
        end
    end

    // Stage p1: published results, held until the next completed window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_min <= '0;
            win_max <= '0;
        end else if (commit) begin
            win_min <= cand_min;
            win_max <= cand_max;
        end
    end

endmodule

// File: rtl/sync_window_avg.sv
// Windowed mean of 2^LOG_N qualified samples with start/busy/abort handshake.
// Define SYNC_WINDOW_AVG_MINMAX_EN to add per-window min/max outputs.
module sync_window_avg
    import sync_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOG_N = 3
) (
    input  logic               clk,
    input  logic               rst,
    sync_window_avg_if.slave   bus
);
    localparam int ACC_W = WIDTH + LOG_N;

    avg_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_p0;
    logic [LOG_N-1:0] cnt_p0;
    logic [ACC_W-1:0] acc_sum;
    logic [WIDTH-1:0] avg_p1;
    logic             clr_win;
    logic             accept;
    logic             commit;

    // Truncating mean; the accumulator is wide enough that no saturation is needed.
    function automatic logic [WIDTH-1:0] trunc_mean(input logic [ACC_W-1:0] total);
        trunc_mean = total[ACC_W-1:LOG_N];
    endfunction

    assign acc_sum = acc_p0 + ACC_W'(bus.x);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort outranks both sample acceptance and window completion.
    always_comb begin
        state_d = state_q;
        clr_win = 1'b0;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ACC;
                    clr_win = 1'b1;
                end
            end
            ACC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    clr_win = 1'b1;
                end else if (bus.x_valid) begin
                    accept = 1'b1;
                    if (&cnt_p0) begin
                        commit  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ACC;
                    clr_win = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: accumulator and sample count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (clr_win) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (accept) begin
            acc_p0 <= acc_sum;
            cnt_p0 <= cnt_p0 + LOG_N'(1);
        end
    end

    // Stage p1: registered mean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_p1 <= '0;
        end else if (commit) begin
            avg_p1 <= trunc_mean(acc_sum);
        end
    end

    assign bus.avg       = avg_p1;
    assign bus.avg_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ACC);

`ifdef SYNC_WINDOW_AVG_MINMAX_EN
    sync_window_minmax #(
        .WIDTH (WIDTH)
    ) u_minmax (
        .clk     (clk),
        .rst     (rst),
        .x       (bus.x),
        .accept  (accept),
        .first   (cnt_p0 == '0),
        .commit  (commit),
        .win_min (bus.win_min),
        .win_max (bus.win_max)
    );
`endif

endmodule

// File: tb/tb_sync_window_avg.sv
// Directed self-checking bench for sync_window_avg (WIDTH=16, LOG_N=3).
module tb_sync_window_avg;
    import sync_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    sync_window_avg_if #(.WIDTH(16)) bus ();

    sync_window_avg #(
        .WIDTH (16),
        .LOG_N (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // One accepted sample followed by 'gap' idle cycles carrying junk on x.
    task automatic send(input logic [15:0] v, input int gap);
        bus.x       = v;
        bus.x_valid = 1'b1;
        tick();
        bus.x_valid = 1'b0;
        bus.x       = 16'hDEAD;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.x = '0; bus.x_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        tick(); tick();
        n_cmp++;
        if (bus.avg !== 16'd0 || bus.avg_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: avg=%0d avg_valid=%b busy=%b required 0/0/0",
                     bus.avg, bus.avg_valid, bus.busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        start_window();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL ramp_busy_after_start: busy=%b required 1", bus.busy);
        end
        for (int i = 1; i <= 7; i++) send(16'(i), 0);
        n_cmp++;
        if (bus.avg_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_before_last: avg_valid=%b busy=%b required 0/1", bus.avg_valid, bus.busy);
        end
        send(16'd8, 0);
        n_cmp++;
        if (bus.avg_valid !== 1'b1 || bus.avg !== 16'd4 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ramp_result: avg=%0d avg_valid=%b busy=%b required 4/1/0",
                     bus.avg, bus.avg_valid, bus.busy);
        end
`ifdef SYNC_WINDOW_AVG_MINMAX_EN
        n_cmp++;
        if (bus.win_min !== 16'd1 || bus.win_max !== 16'd8) begin
            n_bad++;
            $display("FAIL ramp_minmax: min=%0d max=%0d required 1/8", bus.win_min, bus.win_max);
        end
`endif
        tick();
        n_cmp++;
        if (bus.avg_valid !== 1'b0 || bus.avg !== 16'd4 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ramp_pulse_width: avg=%0d avg_valid=%b busy=%b required 4/0/0",
                     bus.avg, bus.avg_valid, bus.busy);
        end
    endtask

    task automatic test_full_scale();
        start_window();
        for (int i = 0; i < 8; i++) send(16'hFFFF, 0);
        n_cmp++;
        if (bus.avg_valid !== 1'b1 || bus.avg !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL full_scale: avg=%h avg_valid=%b required ffff/1", bus.avg, bus.avg_valid);
        end
        tick();
    endtask

    task automatic test_gaps();
        int busy_drop;
        busy_drop = 0;
        start_window();
        for (int i = 1; i <= 8; i++) begin
            bus.x = 16'(10 * i); bus.x_valid = 1'b1;
            tick();
            bus.x_valid = 1'b0; bus.x = 16'hBEEF;
            if (i < 8) begin
                if (bus.busy !== 1'b1) busy_drop++;
                for (int g = 0; g < (i % 4); g++) begin
                    tick();
                    if (bus.busy !== 1'b1) busy_drop++;
                end
            end
        end
        n_cmp++;
        if (busy_drop !== 0) begin
            n_bad++; $display("FAIL gaps_busy: busy low in %0d cycles required 0", busy_drop);
        end
        n_cmp++;
        if (bus.avg_valid !== 1'b1 || bus.avg !== 16'd45) begin
            n_bad++;
            $display("FAIL gaps_result: avg=%0d avg_valid=%b required 45/1", bus.avg, bus.avg_valid);
        end
`ifdef SYNC_WINDOW_AVG_MINMAX_EN
        n_cmp++;
        if (bus.win_min !== 16'd10 || bus.win_max !== 16'd80) begin
            n_bad++;
            $display("FAIL gaps_minmax: min=%0d max=%0d required 10/80", bus.win_min, bus.win_max);
        end
`endif
        tick();
    endtask

    task automatic test_abort();
        start_window();
        for (int i = 0; i < 4; i++) send(16'd100, 0);
        bus.abort = 1'b1; bus.x = 16'd100; bus.x_valid = 1'b1;
        tick();
        bus.abort = 1'b0; bus.x_valid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.avg_valid !== 1'b0 || bus.avg !== 16'd45) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b avg_valid=%b avg=%0d required 0/0/45",
                     bus.busy, bus.avg_valid, bus.avg);
        end
        // abort in IDLE suppresses a simultaneous start
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_blocks_start: busy=%b required 0", bus.busy);
        end
        start_window();
        for (int i = 0; i < 8; i++) send(16'd7, 0);
        n_cmp++;
        if (bus.avg_valid !== 1'b1 || bus.avg !== 16'd7) begin
            n_bad++;
            $display("FAIL abort_next_window: avg=%0d avg_valid=%b required 7/1", bus.avg, bus.avg_valid);
        end
`ifdef SYNC_WINDOW_AVG_MINMAX_EN
        n_cmp++;
        if (bus.win_min !== 16'd7 || bus.win_max !== 16'd7) begin
            n_bad++;
            $display("FAIL abort_minmax: min=%0d max=%0d required 7/7", bus.win_min, bus.win_max);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        start_window();
        for (int i = 1; i <= 3; i++) send(16'(2 * i), 0);
        bus.start = 1'b1;
        send(16'd8, 0);
        bus.start = 1'b0;
        for (int i = 5; i <= 8; i++) send(16'(2 * i), 0);
        n_cmp++;
        if (bus.avg_valid !== 1'b1 || bus.avg !== 16'd9) begin
            n_bad++;
            $display("FAIL start_in_acc: avg=%0d avg_valid=%b required 9/1", bus.avg, bus.avg_valid);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.avg_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_back_rearm: busy=%b avg_valid=%b required 1/0", bus.busy, bus.avg_valid);
        end
        for (int i = 0; i < 8; i++) send(16'd3, 0);
        n_cmp++;
        if (bus.avg_valid !== 1'b1 || bus.avg !== 16'd3) begin
            n_bad++;
            $display("FAIL back_to_back_result: avg=%0d avg_valid=%b required 3/1", bus.avg, bus.avg_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        start_window();
        for (int i = 0; i < 5; i++) send(16'd1000, 0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.avg !== 16'd0 || bus.busy !== 1'b0 || bus.avg_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async: avg=%0d busy=%b avg_valid=%b required 0/0/0",
                     bus.avg, bus.busy, bus.avg_valid);
        end
`ifdef SYNC_WINDOW_AVG_MINMAX_EN
        n_cmp++;
        if (bus.win_min !== 16'd0 || bus.win_max !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_minmax: min=%0d max=%0d required 0/0", bus.win_min, bus.win_max);
        end
`endif
        tick();
        #2 rst = 1'b0;
        tick();
        start_window();
        for (int i = 0; i < 8; i++) send(16'd5, 0);
        n_cmp++;
        if (bus.avg_valid !== 1'b1 || bus.avg !== 16'd5) begin
            n_bad++;
            $display("FAIL reset_mid_fresh: avg=%0d avg_valid=%b required 5/1", bus.avg, bus.avg_valid);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_ramp();
        test_full_scale();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
